// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low, ordered {CA,CB,CC,CD,CE,CF,CG} with CA as the MSB.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StScan
   } state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to active-low 7-segment pattern lookup.
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous shadow capture,
// leading-zero suppression, decimal points and PWM brightness.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned CLK_DIV  = 100000,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [4*DIGITS-1:0]   number,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  blank_lz,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [DIGITS-1:0]     anodes,
   output logic [7:0]            cathodes,
   output logic                  frame_done
);

   localparam int unsigned PrescW = $clog2(CLK_DIV);
   localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_DIV - 1);
   localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [PrescW-1:0]     presc_q, presc_d;
   logic [PWM_BITS-1:0]   pwm_q, pwm_d;

   logic [4*DIGITS-1:0]   num_q, num_d;
   logic [DIGITS-1:0]     dp_q, dp_d;
   logic                  blank_lz_q, blank_lz_d;
   logic [DIGITS-1:0]     lz_q, lz_d;

   logic [DIGITS-1:0]     anodes_q, anodes_d;
   logic [7:0]            cathodes_q, cathodes_d;
   logic                  frame_done_q, frame_done_d;

   logic                  capture;
   logic [DIGITS-1:0]     lz_new;
   logic [3:0]            digit;
   logic                  digit_dp;
   logic                  digit_blank;
   logic [6:0]            dec_seg;

   // Blank mask for the incoming word: zeros above the first nonzero digit, digit 0 exempt.
   always_comb begin
      logic seen;
      seen   = 1'b0;
      lz_new = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (number[4*i +: 4] != 4'h0) begin
            seen = 1'b1;
         end
         lz_new[i] = blank_lz && !seen;
      end
   end

   always_comb begin
      digit       = 4'h0;
      digit_dp    = 1'b0;
      digit_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IdxW'(i)) begin
            digit       = num_q[4*i +: 4];
            digit_dp    = dp_q[i];
            digit_blank = lz_q[i];
         end
      end
   end

   seg_hex_decoder u_hex_decoder (
      .hex (digit),
      .seg (dec_seg)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      presc_d      = presc_q;
      pwm_d        = pwm_q + 1'b1;
      capture      = 1'b0;
      frame_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            capture = 1'b1;
            idx_d   = '0;
            presc_d = '0;
            state_d = StScan;
         end
         StScan: begin
            // Disable wins over a coincident end-of-frame: no pulse, no capture.
            if (!enable) begin
               state_d = StIdle;
            end else if (presc_q == PrescLast) begin
               presc_d = '0;
               if (idx_q == IdxLast) begin
                  idx_d        = '0;
                  capture      = 1'b1;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      num_d      = capture ? number   : num_q;
      dp_d       = capture ? dp_mask  : dp_q;
      blank_lz_d = capture ? blank_lz : blank_lz_q;
      lz_d       = capture ? lz_new   : lz_q;

      // Gating on enable makes the pins go dark on the same edge that leaves SCAN.
      anodes_d   = '1;
      cathodes_d = 8'hFF;
      if (state_q == StScan && enable) begin
         cathodes_d = {digit_blank ? SEG_BLANK : dec_seg, ~digit_dp};
         if (presc_q != '0 && pwm_q <= brightness) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IdxW'(i)) begin
                  anodes_d[i] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         presc_q      <= '0;
         pwm_q        <= '0;
         num_q        <= '0;
         dp_q         <= '0;
         blank_lz_q   <= 1'b0;
         lz_q         <= '0;
         anodes_q     <= '1;
         cathodes_q   <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         presc_q      <= presc_d;
         pwm_q        <= pwm_d;
         num_q        <= num_d;
         dp_q         <= dp_d;
         blank_lz_q   <= blank_lz_d;
         lz_q         <= lz_d;
         anodes_q     <= anodes_d;
         cathodes_q   <= cathodes_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign anodes     = anodes_q;
   assign cathodes   = cathodes_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized self-checking bench for seg_scan_display against a slot/phase arithmetic model.
module tb_seg_scan_display;

   localparam int DIGITS   = 4;
   localparam int CLK_DIV  = 4;
   localparam int PWM_BITS = 2;
   localparam int FRAME    = DIGITS * CLK_DIV;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic [15:0]         number;
   logic [3:0]          dp_mask;
   logic                blank_lz;
   logic [1:0]          brightness;
   logic [3:0]          anodes;
   logic [7:0]          cathodes;
   logic                frame_done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference glyphs, CA..CG active-low.
   logic [6:0] glyph [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Model: idle / loading / scanning, cycles since scan start, free-running pwm cycle count.
   bit m_loading, m_active;
   int m_t, m_cyc;
   int sh_digit [DIGITS];
   bit sh_dp    [DIGITS];
   bit sh_blank [DIGITS];

   always #5 clk = ~clk;

   seg_scan_display #(
      .DIGITS   (DIGITS),
      .CLK_DIV  (CLK_DIV),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .number     (number),
      .dp_mask    (dp_mask),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .anodes     (anodes),
      .cathodes   (cathodes),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_capture();
      for (int i = 0; i < DIGITS; i++) begin
         bit upper_zero;
         upper_zero = 1'b1;
         for (int j = i; j < DIGITS; j++) begin
            if (((number >> (4 * j)) & 16'hF) != 0) upper_zero = 1'b0;
         end
         sh_digit[i] = int'((number >> (4 * i)) & 16'hF);
         sh_dp[i]    = dp_mask[i];
         sh_blank[i] = blank_lz && upper_zero && (i > 0);
      end
   endtask

   task automatic step();
      logic [3:0] e_an;
      logic [7:0] e_cath;
      logic       e_fd;
      int         slot, phase;
      e_an   = 4'hF;
      e_cath = 8'hFF;
      e_fd   = 1'b0;
      if (reset) begin
         m_loading = 0;
         m_active  = 0;
         m_t       = 0;
         m_cyc     = 0;
         for (int i = 0; i < DIGITS; i++) begin
            sh_digit[i] = 0;
            sh_dp[i]    = 0;
            sh_blank[i] = 0;
         end
      end else begin
         if (m_active && enable) begin
            slot  = (m_t / CLK_DIV) % DIGITS;
            phase = m_t % CLK_DIV;
            e_cath = {sh_blank[slot] ? 7'h7F : glyph[sh_digit[slot]], ~sh_dp[slot]};
            if (phase != 0 && (m_cyc % (1 << PWM_BITS)) <= int'(brightness))
               e_an = ~(4'b0001 << slot);
            e_fd = (slot == DIGITS - 1) && (phase == CLK_DIV - 1);
         end
         m_cyc++;
         if (m_loading) begin
            model_capture();
            m_loading = 0;
            m_active  = 1;
            m_t       = 0;
         end else if (m_active) begin
            if (!enable) begin
               m_active = 0;
            end else begin
               m_t++;
               if (m_t % FRAME == 0) model_capture();
            end
         end else if (enable) begin
            m_loading = 1;
         end
      end
      @(posedge clk);
      #1;
      check_eq("anodes", {28'd0, anodes}, {28'd0, e_an});
      check_eq("cathodes", {24'd0, cathodes}, {24'd0, e_cath});
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit found;
      reset      = 1'b1;
      enable     = 1'b1;
      number     = 16'h1234;
      dp_mask    = 4'h0;
      blank_lz   = 1'b0;
      brightness = 2'd3;
      run(3);
      reset = 1'b0;

      // Basic scan at full brightness.
      run(2 + 2 * FRAME + 5);

      // Leading zero suppression with a decimal point on a blanked digit.
      number   = 16'h0050;
      blank_lz = 1'b1;
      dp_mask  = 4'b0100;
      run(2 * FRAME);
      number = 16'h0000;
      run(2 * FRAME);

      // Mid-frame input change must not tear the display.
      number   = 16'h1111;
      blank_lz = 1'b0;
      dp_mask  = 4'h0;
      run(2 * FRAME);
      run(5);
      number = 16'h2222;
      run(2 * FRAME);

      // Minimum brightness.
      brightness = 2'd0;
      run(2 * FRAME);
      brightness = 2'd3;

      // Disable in slot 2.
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         if (m_active && ((m_t / CLK_DIV) % DIGITS) == 2 && (m_t % CLK_DIV) == 1) found = 1'b1;
         else step();
      end
      check_eq("slot2_reached", {31'd0, found}, 32'd1);
      enable = 1'b0;
      run(4);
      enable = 1'b1;
      run(FRAME + 6);

      // Reset mid-frame.
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      run(FRAME + 4);

      // Disable coinciding with the last cycle of a frame.
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         if (m_active && (m_t % FRAME) == FRAME - 1) found = 1'b1;
         else step();
      end
      check_eq("frame_end_reached", {31'd0, found}, 32'd1);
      enable = 1'b0;
      run(3);
      enable = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) number = 16'($urandom);
         if ($urandom_range(7) == 0) dp_mask = 4'($urandom);
         if ($urandom_range(15) == 0) blank_lz = 1'($urandom);
         if ($urandom_range(15) == 0) brightness = 2'($urandom);
         if ($urandom_range(3) == 0 && number[15:12] != 0) number[15:8] = 8'h00;
         if ($urandom_range(63) == 0) enable = ~enable;
         reset = ($urandom_range(255) == 0);
         step();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed 7-segment driver for the board's common-anode digit bank. Scans `DIGITS` hex digits from a packed input word. Each digit holds for `CLK_DIV` clocks, and the anodes blank for one cycle between digits to prevent ghosting. Adds frame-synchronous input capture, leading-zero suppression, a per-digit decimal-point mask, PWM brightness and an enable gate. It sits between the CPU's display/IO register and the FPGA display pins.

## Interface
- `DIGITS`, 8: number of digits, 1..8.
- `CLK_DIV`, 100000: clocks per digit slot, ≥2.
- `PWM_BITS`, 4: brightness resolution, ≥1.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 1 = scan, 0 = all digits dark.
- `number` in 4*DIGITS: digit i = `number[4i+3:4i]`; digit 0 is rightmost.
- `dp_mask` in DIGITS: 1 = light the DP of digit i.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `brightness` in PWM_BITS: duty select; all-ones = full.
- `anodes` out DIGITS: active-low digit selects.
- `cathodes` out 8: active-low, bit order {CA,CB,CC,CD,CE,CF,CG,DP} with CA = bit 7.
- `frame_done` out 1: 1-cycle pulse after the last slot of each frame.

## Operation
- **States:** IDLE, LOAD, SCAN; encoding is implementation choice.
- **IDLE:** outputs dark. `enable`=1 → LOAD.
- **LOAD** (1 cycle): capture `number`, `dp_mask` and `blank_lz` into shadow registers. Set index=0, prescaler=0. → SCAN.
- **SCAN:** prescaler counts 0..CLK_DIV-1. At terminal count:
  - index < DIGITS-1: index increments.
  - index = DIGITS-1: pulse `frame_done`, re-capture the shadow registers in that same cycle, set index=0.
  - There is no LOAD gap between frames.
- **Disable:** `enable`=0 in SCAN → IDLE next cycle. The current frame is abandoned and no `frame_done` pulses.
- **Inputs:** all displayed data comes from the shadow registers only. Input changes mid-frame never tear the display.
- **Leading-zero mask:** computed at capture. Starting from digit DIGITS-1 and moving downward, each digit whose value is 0 is blanked until the first nonzero digit. Digit 0 is never blanked. A blanked digit drives segments CA..CG high; its DP still follows `dp_mask`.
- **PWM:** `pwm_cnt` is a free-running PWM_BITS counter. It is not reset by slot or frame. A digit is lit while `pwm_cnt <= brightness`.
- **Anode i** is low iff: state=SCAN, index=i, prescaler≠0 (ghost guard), and the PWM condition holds.
- **Cathodes** = {seg7(digit), ~dp} for the current index, or 8'hFF in IDLE/LOAD.
- **Hex patterns** (CA..CG, active-low):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, B:1100000
  - C:0110001, D:1000010, E:0110000, F:0111000

## Timing
- **Reset values:** `anodes`=all ones, `cathodes`=8'hFF, `frame_done`=0, state=IDLE, prescaler=0, index=0, pwm_cnt=0, shadows=0.
- `reset` overrides everything, including mid-frame; the block resumes via LOAD only when `enable`=1.
- `anodes`, `cathodes` and `frame_done` are registered. They reflect the state, index, prescaler and pwm_cnt of the previous cycle (1-cycle latency).
- **Frame period:** DIGITS*CLK_DIV cycles in steady state. The first frame after enable costs one extra LOAD cycle.
- **Simultaneous events:** `enable` falling in the terminal cycle of the last slot → IDLE wins; no `frame_done` pulse, no capture.
- **Wrap:** index wraps DIGITS-1 → 0; prescaler wraps CLK_DIV-1 → 0; pwm_cnt wraps at 2^PWM_BITS.

## Structure
- Package `seg_pkg`:
  - 16-entry segment pattern constant array.
  - `SEG_BLANK` = 7'h7F.
  - State enum {IDLE, LOAD, SCAN}.
- Sub-module `seg_hex_decoder`: combinational 4-bit → 7-bit active-low lookup using the package table. Instantiate once, on the muxed digit.
- Prescaler width = $clog2(CLK_DIV); index width = max(1, $clog2(DIGITS)).

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=4, PWM_BITS=2.
- **Reset:** reset held with `enable`=1 → `anodes`=4'hF, `cathodes`=8'hFF, `frame_done`=0; LOAD one cycle after release.
- **Basic scan:** `number`=16'h1234, `brightness`=3, `dp_mask`=0, `blank_lz`=0:
  - slot 0: `anodes`=4'hF for 1 cycle, then 4'b1110 with `cathodes`=8'b10011001 for 3 cycles;
  - slot 3 shows 8'b10011111;
  - `frame_done` pulses every 16 cycles.
- **Leading zeros:** `number`=16'h0050, `blank_lz`=1, `dp_mask`=4'b0100:
  - digit 3 → 8'hFF;
  - digit 2 → 8'hFE;
  - digit 1 → 8'b01001001;
  - digit 0 → 8'b00000011;
  - `number`=0 → only digit 0 lit.
- **Tear-free update:** change `number` 16'h1111→16'h2222 mid-frame → remaining slots still show 1; 2 appears from the slot after `frame_done`.
- **Brightness:** `brightness`=0 → each anode low exactly 1 of every 4 cycles within its slot, and never when prescaler=0.
- **Disable / reset mid-frame:** drop `enable` in slot 2 → dark next cycle, no `frame_done`. Assert `reset` mid-frame → reset values next cycle.
